// File: rtl/fetcher_pkg.sv
// Common definitions for the instruction fetcher.
//   DEFAULT_RESET_PC : default address of the first fetch after reset
//   XLEN / ILEN      : address and instruction widths
//   FETCH_STATE      : fetcher control states
//   REG_IF_ID        : IF/ID pipeline register layout
//   align_pc()       : forces a target onto a word boundary
//   issues_request() : which states drive a bus request
package fetcher_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,  // no request on the bus
    WAIT,  // request outstanding, response will be used
    HOLD,  // word parked in the skid buffer while decode stalls
    FLUSH  // request outstanding, response will be thrown away
  } FETCH_STATE;

  typedef struct packed {
    logic            valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instrAddr;
    logic [XLEN-1:0] pcPlus4;
  } REG_IF_ID;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic issues_request(input FETCH_STATE st);
    return (st == WAIT) || (st == FLUSH);
  endfunction

endpackage

// File: rtl/fetchbuf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture load_instr/load_addr/load_pc_plus4 and mark valid
//   clear             : drop the stored entry (wins over load)
//   valid             : an entry is stored
//   instr, instr_addr, pc_plus4 : the stored entry
module fetchbuf
  import fetcher_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [ILEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_pc_plus4,
  output logic            valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_addr,
  output logic [XLEN-1:0] pc_plus4
);

  // Only the valid flag is reset; the payload is meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid      <= 1'b1;
      instr      <= load_instr;
      instr_addr <= load_addr;
      pc_plus4   <= load_pc_plus4;
    end
  end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: issues one word request at a time on the
// instruction bus and fills the IF/ID register, absorbing decode stalls with
// a one-entry skid buffer and handling execute-stage redirects.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bubbleHold     : decode stall, IF/ID must hold
//   redirectValid  : taken branch/jump from execute
//   redirectPc     : redirect target (low two bits ignored)
//   ireqValid      : instruction-bus request valid
//   ireqAddr       : instruction-bus request address (current pc)
//   irespDataOk    : response strobe for the outstanding request
//   irespData      : fetched instruction word
//   moduleOut      : IF/ID register
module fetcher
  import fetcher_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubbleHold,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPc,
  output logic            ireqValid,
  output logic [XLEN-1:0] ireqAddr,
  input  logic            irespDataOk,
  input  logic [ILEN-1:0] irespData,
  output REG_IF_ID        moduleOut
);

  FETCH_STATE      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] saved_target;
  logic [XLEN-1:0] redirect_target;

  logic            buf_load;
  logic            buf_clear;
  logic            buf_valid;
  logic [ILEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_addr;
  logic [XLEN-1:0] buf_pc_plus4;

  always_comb begin
    pc_plus4        = pc + 64'd4;
    redirect_target = align_pc(redirectPc);
    // A response that arrives during a stall is parked instead of written.
    buf_load        = (state == WAIT) && irespDataOk && bubbleHold && !redirectValid;
    // The parked word leaves on stall release, or is dropped by a redirect.
    buf_clear       = (state == HOLD) && (redirectValid || !bubbleHold);
  end

  // The request is a pure decode of the state register; pc is held until the
  // response arrives, so the address is stable for the whole request.
  assign ireqValid = issues_request(state);
  assign ireqAddr  = pc;

  fetchbuf u_fetchbuf (
    .clk           (clk),
    .rst           (rst),
    .load          (buf_load),
    .clear         (buf_clear),
    .load_instr    (irespData),
    .load_addr     (pc),
    .load_pc_plus4 (pc_plus4),
    .valid         (buf_valid),
    .instr         (buf_instr),
    .instr_addr    (buf_addr),
    .pc_plus4      (buf_pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      moduleOut.valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= WAIT;
          if (redirectValid) begin
            pc              <= redirect_target;
            moduleOut.valid <= 1'b0;
          end
        end

        WAIT: begin
          if (redirectValid) begin
            moduleOut.valid <= 1'b0;
            if (irespDataOk) begin
              // Bus is free this cycle: go straight to the target.
              pc <= redirect_target;
            end else begin
              // Request cannot be cancelled; remember where to go after it.
              saved_target <= redirect_target;
              state        <= FLUSH;
            end
          end else if (irespDataOk) begin
            pc <= pc_plus4;
            if (bubbleHold) begin
              state <= HOLD;
            end else begin
              moduleOut <= '{valid: 1'b1, instr: irespData, instrAddr: pc, pcPlus4: pc_plus4};
            end
          end else if (!bubbleHold) begin
            moduleOut.valid <= 1'b0;
          end
        end

        HOLD: begin
          if (redirectValid) begin
            pc              <= redirect_target;
            moduleOut.valid <= 1'b0;
            state           <= WAIT;
          end else if (!bubbleHold) begin
            moduleOut <= '{valid: buf_valid, instr: buf_instr, instrAddr: buf_addr,
                           pcPlus4: buf_pc_plus4};
            state     <= WAIT;
          end
        end

        FLUSH: begin
          if (redirectValid) begin
            saved_target <= redirect_target;
          end
          if (irespDataOk) begin
            // A redirect in the same cycle as the discarded response wins.
            pc    <= redirectValid ? redirect_target : saved_target;
            state <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 bubbleHold  input  1  decode stall; the IF/ID register must hold its contents.
REQ-005 redirectValid  input  1  branch/jump taken, from execute.
REQ-006 redirectPc  input  64  redirect target; bits [1:0] ignored and treated as 0.
REQ-007 ireqValid  output  1  instruction-bus request valid.
REQ-008 ireqAddr  output  64  instruction-bus request address.
REQ-009 irespDataOk  input  1  response strobe for the outstanding request.
REQ-010 irespData  input  32  fetched instruction word.
REQ-011 moduleOut  output  REG_IF_ID  IF/ID register; fields valid, instr, instrAddr, pcPlus4.

Function
REQ-012 State machine SHALL use states IDLE, WAIT, HOLD and FLUSH.
- IDLE: no request.
- WAIT: request outstanding.
- HOLD: word buffered, downstream stalled.
- FLUSH: outstanding request whose response is discarded.
REQ-013 ireqValid SHALL be 1 only in WAIT and FLUSH.
- ireqAddr SHALL equal the pc register and stay stable until irespDataOk.
- No request SHALL be cancelled once issued.
REQ-014 IDLE SHALL move to WAIT unconditionally on the next cycle; the first request is RESET_PC one cycle after rst deasserts.
REQ-015 In WAIT, when irespDataOk=1, bubbleHold=0 and redirectValid=0:
- next-cycle moduleOut = {valid=1, instr=irespData, instrAddr=pc, pcPlus4=pc+4};
- pc <= pc+4; state stays WAIT.
- Latency is one cycle from response to IF/ID.
- Back-to-back responses yield one instruction per cycle.
REQ-016 In WAIT, when irespDataOk=1 and bubbleHold=1 (no redirect):
- moduleOut SHALL hold;
- the word, pc and pc+4 SHALL be captured into a one-entry buffer;
- pc <= pc+4; state -> HOLD.
REQ-017 In HOLD, when bubbleHold=0 and no redirect: moduleOut <= buffered entry with valid=1; buffer freed; state -> WAIT.
REQ-018 In WAIT with irespDataOk=0: moduleOut.valid <= 0 when bubbleHold=0; otherwise moduleOut holds.
REQ-019 redirectValid SHALL have priority over bubbleHold and over a same-cycle response.
- moduleOut.valid <= 0 on the next cycle.
- pc <= {redirectPc[63:2],2'b00}.
- IDLE/HOLD: buffer dropped; state -> WAIT.
- WAIT with irespDataOk=1: response discarded; state stays WAIT at the new pc.
- WAIT with irespDataOk=0: target saved; state -> FLUSH.
- FLUSH: a new redirect overwrites the saved target.
REQ-020 In FLUSH, on irespDataOk the word SHALL be discarded, pc <= saved target, state -> WAIT; moduleOut.valid stays 0 throughout FLUSH.
REQ-021 pc arithmetic is 64-bit modulo 2^64; pc+4 at 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.

Reset
REQ-022 On rst=1 at posedge clk:
- state <= IDLE; pc <= RESET_PC;
- moduleOut.valid <= 0; buffer invalid; ireqValid = 0 in the following cycle.
REQ-023 rst SHALL override all other inputs, including mid-request; the instruction bus is reset by the same rst, so no stale response is expected.
REQ-024 moduleOut fields other than valid are don't-care after reset.

Structure
REQ-025 The FETCH_STATE enum and the RESET_PC default SHALL live in the common package alongside REG_IF_ID.
REQ-026 The one-entry skid buffer SHALL be a sub-module named fetchbuf.
- Inputs: load, clear.
- Outputs: valid and the stored {instr, instrAddr, pcPlus4}.
- pc and FSM logic stay in fetcher.

Verification
REQ-027 Reset release, dataOk one cycle after each request with instr 0x00000013 -> ireqAddr 0x80000000, 0x80000004, ...; moduleOut.valid=1 every cycle from the first response+1, instrAddr matching.
REQ-028 bubbleHold=1 for 3 cycles while the response at 0x80000008 arrives -> moduleOut holds 0x80000004; ireqValid=0 in HOLD; after release, instrAddr=0x80000008 then a request to 0x8000000C.
REQ-029 redirectValid with redirectPc=0x80001002 while a request is outstanding (dataOk 2 cycles later) -> state FLUSH; response discarded; next ireqAddr=0x80001000; no valid output of the discarded word.
REQ-030 redirectValid, irespDataOk and bubbleHold all 1 in the same cycle -> next moduleOut.valid=0; next ireqAddr=target; the response is never emitted.
REQ-031 rst asserted mid-WAIT at pc 0x80000010 -> next cycle ireqValid=0, moduleOut.valid=0; the following request is to 0x80000000.
REQ-032 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC with one response -> pcPlus4=0; next ireqAddr=0.
